// File: rtl/matrix_pe_feeder.sv
// Sequencer feeding parallel_pe from the neuron/weight SRAMs and writing its
// 32-bit results to the output buffer, one output channel after another.
module matrix_pe_feeder #(
    parameter int IC_W = 8,
    parameter int OC_W = 8,
    parameter int WA_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IC_W-1:0] cfg_ic,
    input  logic [OC_W-1:0] cfg_oc,
    output logic            busy,
    output logic            done,
    output logic            nram_rd_en,
    output logic [IC_W-1:0] nram_rd_addr,
    input  logic [511:0]    nram_rd_data,
    output logic            wram_rd_en,
    output logic [WA_W-1:0] wram_rd_addr,
    input  logic [511:0]    wram_rd_data,
    output logic [511:0]    pe_neuron,
    output logic [511:0]    pe_weight,
    output logic [1:0]      pe_ctl,
    output logic            pe_vld,
    input  logic [31:0]     pe_result,
    input  logic            pe_vld_o,
    output logic            out_wr_en,
    output logic [OC_W-1:0] out_wr_addr,
    output logic [31:0]     out_wr_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [IC_W-1:0] ic_q, c_cnt;
    logic [OC_W-1:0] oc_q, o_cnt, wb_cnt;
    logic [WA_W-1:0] w_addr;
    logic            pe_vld_q;
    logic [1:0]      pe_ctl_q;
    logic            done_q;
    logic            cfg_ok, launch, issue, c_first, c_last, o_last, collect, drained;

    assign cfg_ok  = (cfg_ic != '0) && (cfg_oc != '0);
    assign launch  = (state_q == IDLE) && start;
    assign issue   = (state_q == RUN);
    assign c_first = (c_cnt == '0);
    assign c_last  = (c_cnt == ic_q - IC_W'(1));
    assign o_last  = (o_cnt == oc_q - OC_W'(1));
    // Results only count while an operation is live; stray PE beats in IDLE are dropped.
    assign collect = pe_vld_o && (state_q != IDLE);
    assign drained = (state_q == DRAIN) && (wb_cnt == oc_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (launch && cfg_ok)   state_d = RUN;
            RUN:     if (c_last && o_last)   state_d = DRAIN;
            DRAIN:   if (drained)            state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // The weight address runs linearly through o*IC+c, so no multiplier is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic_q   <= '0;
            oc_q   <= '0;
            c_cnt  <= '0;
            o_cnt  <= '0;
            w_addr <= '0;
            wb_cnt <= '0;
        end else if (launch) begin
            ic_q   <= cfg_ic;
            oc_q   <= cfg_oc;
            c_cnt  <= '0;
            o_cnt  <= '0;
            w_addr <= '0;
            wb_cnt <= '0;
        end else begin
            if (issue) begin
                w_addr <= w_addr + WA_W'(1);
                if (c_last) begin
                    c_cnt <= '0;
                    o_cnt <= o_cnt + OC_W'(1);
                end else begin
                    c_cnt <= c_cnt + IC_W'(1);
                end
            end
            if (collect) wb_cnt <= wb_cnt + OC_W'(1);
        end
    end

    // Frame tags travel one cycle behind the read so they line up with SRAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_vld_q    <= 1'b0;
            pe_ctl_q    <= 2'b00;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
            done_q      <= 1'b0;
        end else begin
            pe_vld_q  <= issue;
            pe_ctl_q  <= issue ? {c_last, c_first} : 2'b00;
            out_wr_en <= collect;
            if (collect) begin
                out_wr_addr <= wb_cnt;
                out_wr_data <= pe_result;
            end
            done_q <= (launch && !cfg_ok) || drained;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign nram_rd_en   = issue;
    assign wram_rd_en   = issue;
    assign nram_rd_addr = c_cnt;
    assign wram_rd_addr = w_addr;
    assign pe_vld       = pe_vld_q;
    assign pe_ctl       = pe_ctl_q;
    // Data buses idle at zero between beats (and through reset).
    assign pe_neuron    = pe_vld_q ? nram_rd_data : '0;
    assign pe_weight    = pe_vld_q ? wram_rd_data : '0;

endmodule

// File: tb/tb_matrix_pe_feeder.sv
// Bench for matrix_pe_feeder: SRAM and PE stand-ins plus cycle-exact expectations.
module tb_matrix_pe_feeder;
    localparam int IC_W = 8;
    localparam int OC_W = 8;
    localparam int WA_W = 16;

    logic            clk = 1'b0;
    logic            rst_n, start;
    logic [IC_W-1:0] cfg_ic;
    logic [OC_W-1:0] cfg_oc;
    logic            busy, done;
    logic            nram_rd_en, wram_rd_en;
    logic [IC_W-1:0] nram_rd_addr;
    logic [WA_W-1:0] wram_rd_addr;
    logic [511:0]    nram_rd_data = '0;
    logic [511:0]    wram_rd_data = '0;
    logic [511:0]    pe_neuron, pe_weight;
    logic [1:0]      pe_ctl;
    logic            pe_vld;
    logic [31:0]     pe_result;
    logic            pe_vld_o;
    logic            out_wr_en;
    logic [OC_W-1:0] out_wr_addr;
    logic [31:0]     out_wr_data;

    matrix_pe_feeder #(.IC_W(IC_W), .OC_W(OC_W), .WA_W(WA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_ic(cfg_ic), .cfg_oc(cfg_oc),
        .busy(busy), .done(done),
        .nram_rd_en(nram_rd_en), .nram_rd_addr(nram_rd_addr), .nram_rd_data(nram_rd_data),
        .wram_rd_en(wram_rd_en), .wram_rd_addr(wram_rd_addr), .wram_rd_data(wram_rd_data),
        .pe_neuron(pe_neuron), .pe_weight(pe_weight), .pe_ctl(pe_ctl), .pe_vld(pe_vld),
        .pe_result(pe_result), .pe_vld_o(pe_vld_o),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
    );

    always #5 clk = ~clk;

    int          passed, total, fails, cyc;
    int          dmode;
    int unsigned seed;
    logic [31:0] wr_obs[$];
    logic [31:0] lastw;

    function automatic logic [15:0] hsh(int unsigned a, int unsigned l, int unsigned s);
        int unsigned x;
        x = a * 32'd2654435761 + l * 32'd40503 + s;
        x = x ^ (x >> 15);
        x = x * 32'h2c1b3c6d;
        x = x ^ (x >> 12);
        return x[15:0];
    endfunction

    // Buffer contents are a pure function of address, so no 64K-entry arrays are needed.
    function automatic logic [511:0] nword(int unsigned a);
        logic [511:0] v;
        for (int l = 0; l < 32; l++)
            v[l*16 +: 16] = (dmode != 0) ? 16'd1 : hsh(a, l, seed ^ 32'h1234);
        return v;
    endfunction

    function automatic logic [511:0] wword(int unsigned a);
        logic [511:0] v;
        for (int l = 0; l < 32; l++)
            v[l*16 +: 16] = (dmode == 1) ? 16'd2 : (dmode == 2) ? 16'(a + 1) : hsh(a, l, seed);
        return v;
    endfunction

    function automatic logic [31:0] dot(logic [511:0] a, logic [511:0] b);
        int s;
        s = 0;
        for (int l = 0; l < 32; l++)
            s += int'($signed(a[l*16 +: 16])) * int'($signed(b[l*16 +: 16]));
        return 32'(s);
    endfunction

    function automatic logic [31:0] obs_at(int i);
        return (i < wr_obs.size()) ? wr_obs[i] : 32'hxxxxxxxx;
    endfunction

    // SRAMs with one cycle of read latency
    always @(posedge clk) begin
        if (nram_rd_en) nram_rd_data <= nword(32'(nram_rd_addr));
        if (wram_rd_en) wram_rd_data <= wword(32'(wram_rd_addr));
    end

    // PE stand-in: 32 signed 16-bit lanes, accumulate across chunks, result one cycle after last
    logic [31:0] psum;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum      <= '0;
            pe_vld_o  <= 1'b0;
            pe_result <= '0;
        end else begin
            pe_vld_o <= 1'b0;
            if (pe_vld) begin
                psum <= (pe_ctl[0] ? 32'd0 : psum) + dot(pe_neuron, pe_weight);
                if (pe_ctl[1]) begin
                    pe_vld_o  <= 1'b1;
                    pe_result <= (pe_ctl[0] ? 32'd0 : psum) + dot(pe_neuron, pe_weight);
                end
            end
        end
    end

    task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            if (fails <= 40)
                $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_zero(string pfx);
        chk({pfx, "_busy"},  512'(busy), 512'(0));
        chk({pfx, "_done"},  512'(done), 512'(0));
        chk({pfx, "_nren"},  512'(nram_rd_en), 512'(0));
        chk({pfx, "_nradr"}, 512'(nram_rd_addr), 512'(0));
        chk({pfx, "_wren"},  512'(wram_rd_en), 512'(0));
        chk({pfx, "_wradr"}, 512'(wram_rd_addr), 512'(0));
        chk({pfx, "_pvld"},  512'(pe_vld), 512'(0));
        chk({pfx, "_pctl"},  512'(pe_ctl), 512'(0));
        chk({pfx, "_pneu"},  pe_neuron, 512'(0));
        chk({pfx, "_pwgt"},  pe_weight, 512'(0));
        chk({pfx, "_wen"},   512'(out_wr_en), 512'(0));
        chk({pfx, "_wadr"},  512'(out_wr_addr), 512'(0));
        chk({pfx, "_wdat"},  512'(out_wr_data), 512'(0));
    endtask

    // One operation, checked every cycle against the timing formulas in terms of T=IC*OC.
    task automatic run_op(int ic, int oc, int rp, bit pre, bit chain, int nic, int noc, int abort_at);
        int          tt, k, c, o;
        bit          e_rd, e_pv, e_wr;
        logic [31:0] s;
        logic [31:0] er[$];
        tt = ic * oc;
        er.delete();
        for (int oi = 0; oi < oc; oi++) begin
            s = '0;
            for (int ci = 0; ci < ic; ci++) s += dot(nword(ci), wword(oi * ic + ci));
            er.push_back(s);
        end
        wr_obs.delete();
        lastw = 'x;
        if (!pre) begin
            @(posedge clk); #1;
            start = 1'b1; cfg_ic = IC_W'(ic); cfg_oc = OC_W'(oc);
            @(negedge clk);
            cyc = 0;
            chk("c0_busy", 512'(busy), 512'(0));
            chk("c0_rd", 512'(nram_rd_en), 512'(0));
        end
        for (int t = 1; t <= tt + 4; t++) begin
            @(posedge clk); #1;
            cyc = t;
            start = (t == rp) || (chain && t == tt + 4);
            if (t == 1) begin cfg_ic = IC_W'($urandom); cfg_oc = OC_W'($urandom); end
            if (t == rp) begin cfg_ic = 1; cfg_oc = 1; end
            if (chain && t == tt + 4) begin cfg_ic = IC_W'(nic); cfg_oc = OC_W'(noc); end
            if (t == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_zero("abort");
                break;
            end
            @(negedge clk);
            e_rd = (t <= tt);
            chk("nram_en", 512'(nram_rd_en), 512'(e_rd));
            chk("wram_en", 512'(wram_rd_en), 512'(e_rd));
            if (e_rd) begin
                chk("nram_adr", 512'(nram_rd_addr), 512'((t - 1) % ic));
                chk("wram_adr", 512'(wram_rd_addr), 512'(t - 1));
                lastw = 32'(wram_rd_addr);
            end
            e_pv = (t >= 2) && (t <= tt + 1);
            chk("pe_vld", 512'(pe_vld), 512'(e_pv));
            if (e_pv) begin
                k = t - 2;
                c = k % ic;
                chk("pe_ctl", 512'(pe_ctl), 512'({c == ic - 1, c == 0}));
                chk("pe_neuron", pe_neuron, nword(c));
                chk("pe_weight", pe_weight, wword(k));
            end else begin
                chk("pe_ctl_idle", 512'(pe_ctl), 512'(0));
            end
            e_wr = (t >= 3 + ic) && (t <= tt + 3) && ((t - 3) % ic == 0);
            chk("wr_en", 512'(out_wr_en), 512'(e_wr));
            if (out_wr_en) wr_obs.push_back(out_wr_data);
            if (e_wr) begin
                o = (t - 3) / ic - 1;
                chk("wr_addr", 512'(out_wr_addr), 512'(o));
                chk("wr_data", 512'(out_wr_data), 512'(er[o]));
            end
            chk("busy", 512'(busy), 512'(t <= tt + 3));
            chk("done", 512'(done), 512'(t == tt + 4));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        passed = 0; total = 0; fails = 0; cyc = 0;
        dmode = 0; seed = $urandom;
        rst_n = 1'b1; start = 1'b0; cfg_ic = '0; cfg_oc = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        @(posedge clk); #1 rst_n = 1'b1;

        // IC=2, OC=1, constant lanes
        dmode = 1;
        run_op(2, 1, -1, 0, 0, 0, 0, -1);
        chk("t1_nwr", 512'(wr_obs.size()), 512'(1));
        chk("t1_d0", 512'(obs_at(0)), 512'(128));

        // IC=1, OC=3, weight chunk o lanes = o+1
        dmode = 2;
        run_op(1, 3, -1, 0, 0, 0, 0, -1);
        chk("t2_nwr", 512'(wr_obs.size()), 512'(3));
        chk("t2_d0", 512'(obs_at(0)), 512'(32));
        chk("t2_d1", 512'(obs_at(1)), 512'(64));
        chk("t2_d2", 512'(obs_at(2)), 512'(96));

        // zero chunk count: immediate done, nothing issued
        @(posedge clk); #1;
        start = 1'b1; cfg_ic = 0; cfg_oc = 4;
        @(negedge clk); cyc = 0;
        chk("z0_done", 512'(done), 512'(0));
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); cyc = 1;
        chk("z1_done", 512'(done), 512'(1));
        chk("z1_busy", 512'(busy), 512'(0));
        chk("z1_rd", 512'(nram_rd_en | wram_rd_en), 512'(0));
        @(negedge clk); cyc = 2;
        chk("z2_done", 512'(done), 512'(0));
        chk("z2_busy", 512'(busy), 512'(0));

        // start re-pulsed mid-run with different config
        dmode = 0; seed = $urandom;
        run_op(4, 2, 3, 0, 0, 0, 0, -1);
        chk("t4_nwr", 512'(wr_obs.size()), 512'(2));

        // back-to-back: next start in the done cycle
        run_op(2, 2, -1, 0, 1, 3, 1, -1);
        run_op(3, 1, -1, 1, 0, 0, 0, -1);
        chk("chain_nwr", 512'(wr_obs.size()), 512'(1));

        // reset mid-operation, then a clean run
        run_op(3, 3, -1, 0, 0, 0, 0, 4);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); cyc = i;
            chk("post_rst_done", 512'(done), 512'(0));
            chk("post_rst_busy", 512'(busy), 512'(0));
        end
        dmode = 1;
        run_op(1, 1, -1, 0, 0, 0, 0, -1);
        chk("fresh_nwr", 512'(wr_obs.size()), 512'(1));

        // randomized shapes and data
        for (int r = 0; r < 4; r++) begin
            dmode = 0; seed = $urandom;
            run_op(int'($urandom_range(1, 6)), int'($urandom_range(1, 5)), 2, 0, 0, 0, 0, -1);
        end

        // maximum configuration
        dmode = 0; seed = $urandom;
        run_op(255, 255, -1, 0, 0, 0, 0, -1);
        chk("big_lastw", 512'(lastw), 512'(65024));
        chk("big_nwr", 512'(wr_obs.size()), 512'(255));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/matrix_pe_feeder.md
# matrix_pe_feeder

Sequencer that drives `parallel_pe` from the neuron and weight buffers and collects its results. On `start` it walks every output channel and streams that channel's input chunks into the PE, one per cycle, with correct first/last `ctl` framing. It writes each 32-bit dot-product result into the output buffer and signals completion. It sits between the on-chip SRAMs (1-cycle read latency) and the PE instance.

## Interface
- `IC_W`, default 8: width of the chunk-count config and the neuron-buffer address.
- `OC_W`, default 8: width of the output-count config and the output-buffer address.
- `WA_W`, default 16: weight-buffer address width; must satisfy WA_W ≥ IC_W+OC_W.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle start request; sampled only in IDLE.
- `cfg_ic` in IC_W: number of 512-bit chunks per output; latched at start.
- `cfg_oc` in OC_W: number of outputs; latched at start.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `nram_rd_en` out 1: neuron buffer read enable.
- `nram_rd_addr` out IC_W: neuron buffer read address.
- `nram_rd_data` in 512: neuron data, valid the cycle after `nram_rd_en`.
- `wram_rd_en` out 1: weight buffer read enable.
- `wram_rd_addr` out WA_W: weight buffer read address.
- `wram_rd_data` in 512: weight data, valid the cycle after `wram_rd_en`.
- `pe_neuron` out 512: to PE `neuron`; combinational pass of `nram_rd_data`.
- `pe_weight` out 512: to PE `weight`; combinational pass of `wram_rd_data`.
- `pe_ctl` out 2: to PE `ctl`. Bit 0 marks the first chunk, which restarts psum; bit 1 marks the last chunk, which emits the result.
- `pe_vld` out 1: to PE `vld_i`.
- `pe_result` in 32: from PE `result`.
- `pe_vld_o` in 1: from PE `vld_o`.
- `out_wr_en` out 1: output buffer write enable.
- `out_wr_addr` out OC_W: output buffer write address.
- `out_wr_data` out 32: output buffer write data.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE to RUN: `start` is high and latched `cfg_ic`≠0 and `cfg_oc`≠0.
- IDLE with `start` and a zero config: no reads are issued, busy stays 0, and `done` pulses the next cycle.
- RUN: one read pair per cycle on both buffers (`nram_rd_en`=`wram_rd_en`=1).
  - Iteration order: o=0..OC-1 outer, c=0..IC-1 inner.
  - `nram_rd_addr`=c.
  - `wram_rd_addr`=o·IC+c, generated by a running incrementing counter; no multiplier.
- RUN to DRAIN: after issuing the read for (OC-1, IC-1).
- DRAIN to IDLE: once OC results have been written.
- Issue stage: tags first=(c==0) and last=(c==IC-1) and registers them with the read enable. One cycle later they appear as `pe_vld` and `pe_ctl`={last,first}, aligned with the SRAM data. When IC=1, `pe_ctl`=2'b11 on every beat.
- Collect stage: on each `pe_vld_o`, register a write: `out_wr_en`=1, `out_wr_data`=`pe_result`, `out_wr_addr`=wb counter. The wb counter then increments.
- `start` while busy is ignored. Config changes while busy have no effect.
- Reset (at any time, including mid-operation):
  - All outputs go to 0 and the FSM returns to IDLE.
  - All counters clear.
  - No `done` is produced for the aborted operation.

## Timing
- Let T = IC·OC.
- `start` is sampled at the edge ending cycle 0.
- Reads: `nram_rd_en`/`wram_rd_en` are high for cycles 1..T, with no bubbles.
- PE drive: `pe_vld` is high for cycles 2..T+1.
  - `pe_ctl[0]` is high at cycles 2+o·IC.
  - `pe_ctl[1]` is high at cycles 1+(o+1)·IC.
- PE return: `pe_vld_o` is high at cycles 2+(o+1)·IC.
- Writes: `out_wr_en` is high at cycles 3+(o+1)·IC. The final write is at cycle T+3.
- `busy`: high for cycles 1..T+3.
- `done`: high at cycle T+4, with `busy` low.
- A new `start` is accepted in the `done` cycle.
- End-to-end latency from start to done: T+4 cycles.
- Address wrap: counters are sized so that no wrap occurs for IC and OC up to 2^IC_W−1 and 2^OC_W−1.

## Test plan
- IC=2, OC=1; all neuron lanes = 1, all weight lanes = 2:
  - `pe_ctl` sequence is 01, 10.
  - One write: addr 0, data 128, at cycle 5.
  - `done` at cycle 6.
- IC=1, OC=3; weight chunk o lanes = o+1; neuron lanes = 1:
  - `pe_ctl`=11 on three consecutive beats.
  - Writes of 32, 64, 96 to addrs 0..2, back-to-back at cycles 4..6.
  - `done` at cycle 7.
- `cfg_ic`=0, OC=4:
  - No read enables, `busy` stays 0.
  - `done` at cycle 1.
- `start` re-pulsed at cycle 3 during an IC=4, OC=2 run:
  - Ignored; exactly 2 writes.
  - `done` only at cycle 12.
- `rst_n` dropped at cycle 4 of an IC=3, OC=3 run:
  - All outputs immediately 0; no `done`.
  - A fresh IC=1, OC=1 start afterwards completes normally with `done` at cycle 5.
- IC=255, OC=255: last `wram_rd_addr` = 65024; 255 writes; `done` at cycle 65029.
